gamma_lut_ctrl: RTL and testbench
=================================

Name: gamma_lut_ctrl

Overview:
Programmable replacement for the fixed gamma table in the colour pipeline. Holds two 256-entry gamma banks (active and shadow) and applies the active bank to RGB pixels with 1-cycle latency. A host/ISP-config interface writes the shadow bank and commits it. The bank swap is applied at the next frame start, so no frame ever mixes two tables.

Parameters:
COLOR_DEPTH, 8, bits per colour channel; table depth = 2**COLOR_DEPTH
FS_BIT, 0, index of the frame-start flag inside i_user

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
i_ready  in  1  downstream ready
i_valid  in  1  input pixel valid
i_data  in  COLOR_DEPTH x3  input pixel, [2]=R [1]=G [0]=B
o_ready  out  1  upstream ready, equal to i_ready
o_valid  out  1  output pixel valid
o_data  out  COLOR_DEPTH x3  corrected pixel
i_user  in  8  sync sideband; bit FS_BIT = first beat of frame
o_user  out  8  i_user delayed with the data
isp_ctrl  in  16  gamma_en = isp_ctrl[0] & isp_ctrl[15]
cfg_we  in  1  write strobe to the shadow bank
cfg_addr  in  COLOR_DEPTH  shadow entry index
cfg_wdata  in  COLOR_DEPTH  shadow entry value
cfg_commit  in  1  single-cycle pulse: request shadow->active swap
cfg_busy  out  1  writes/commit currently ignored
cfg_pending  out  1  commit accepted, swap not yet applied
active_bank  out  1  index of the bank in use

Behaviour:
- Reset values: o_valid=0, o_data=0, o_user=0, cfg_pending=0, active_bank=0, cfg_busy=1. FSM enters INIT.
- FSM states are INIT, IDLE and PEND.
- INIT:
  - A counter n runs 0..2**COLOR_DEPTH-1. Each cycle writes bank0[n]=bank1[n]=n (identity).
  - After the last entry, go to IDLE. INIT takes exactly 256 cycles for the default depth.
  - cfg_busy=1 throughout INIT; cfg_we and cfg_commit are ignored.
- IDLE:
  - cfg_busy=0.
  - cfg_we writes shadow[cfg_addr]=cfg_wdata on the same edge.
  - cfg_commit moves the FSM to PEND and sets cfg_pending=1.
  - If cfg_we and cfg_commit are asserted together, the write lands first; the commit includes it.
- PEND:
  - cfg_busy=1; cfg_we and cfg_commit are ignored.
  - Swap trigger A: an input beat with i_valid=1 and i_user[FS_BIT]=1. That beat is already looked up in the new bank, via effective select = ~active_bank for that beat.
  - Swap trigger B: gamma_en=0 in any cycle, so the swap takes effect on the next edge with no tearing risk.
  - On swap: active_bank toggles, cfg_pending=0, FSM returns to IDLE.
  - After a swap the shadow holds the previous table; the host rewrites every entry it needs.
- Datapath:
  - o_ready = i_ready, combinational.
  - Pixel accepted when i_valid=1; latency is exactly 1 cycle.
  - Next cycle: o_valid=1, o_user = that beat's i_user, o_data[c] = gamma_en ? bank[sel][i_data[c]] : i_data[c].
  - o_valid=0 in the cycle after i_valid=0. o_data and o_user hold their last values while o_valid=0.
  - During INIT, pixels still flow; o_data is forced to bypass regardless of gamma_en.
- Width rules: table entries are COLOR_DEPTH bits; no arithmetic, no saturation.
- Reset mid-operation: pipeline contents are lost, any pending commit is dropped, and both banks are re-initialised to identity.
- Bank storage: register arrays, 3 read ports per bank (one per channel) plus 1 write port. No RAM-primitive dependency.

Decomposition:
- Shared package common:
  - FSM state enum gamma_lut_state_t {INIT, IDLE, PEND}
  - localparam GAMMA_LUT_DEPTH = 2**COLOR_DEPTH
  - the frame-start bit position constant
- One sub-module gamma_lut_bank: 2**COLOR_DEPTH x COLOR_DEPTH register array with 1 write port and 3 asynchronous read ports. Instantiated twice.
- Controller FSM, counter and output pipeline live in gamma_lut_ctrl.

Test Plan:
1. Reset, no cfg activity for 256 cycles, with isp_ctrl=16'h8001 → cfg_busy=1 for exactly 256 cycles. Then pixel (10,128,255) returns (10,128,255) one cycle later (identity).
2. Write shadow[x]=255-x for all x, pulse cfg_commit, stream pixels (5,5,5) with no frame start → output stays (5,5,5) and cfg_pending=1. The next beat with i_user[0]=1 outputs (250,250,250); active_bank=1 on the following cycle.
3. While in PEND, cfg_we with addr 5, data 0 → ignored. After the swap, pixel 5 → 250 (not 0).
4. isp_ctrl=16'h0001 (gamma_en=0) plus cfg_commit → swap applied on the next edge without a frame start; output equals input throughout.
5. Assert rst mid-PEND while the stream is active → next cycle o_valid=0 and cfg_pending=0; INIT reruns; afterwards pixel 5 → 5.
6. Random i_valid gaps with i_user patterns → o_valid/o_user equal i_valid/i_user delayed by 1; o_ready tracks i_ready combinationally.

Source files
------------

// File: rtl/gamma_lut_ctrl_pkg.sv
// Shared types and constants for the programmable gamma LUT controller.
// Holds the controller state encoding and the default table geometry.
package gamma_lut_ctrl_pkg;

    localparam int COLOR_DEPTH_DEF = 8;
    localparam int GAMMA_LUT_DEPTH = 2**COLOR_DEPTH_DEF;
    localparam int FS_BIT_POS      = 0;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        PEND = 2'd2
    } gamma_lut_state_t;

endpackage

// File: rtl/gamma_lut_bank.sv
// One gamma table: register array with a single write port and three
// asynchronous read ports (one per colour channel).
module gamma_lut_bank
    import gamma_lut_ctrl_pkg::*;
#(
    parameter int W = COLOR_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [W-1:0]      waddr,
    input  logic [W-1:0]      wdata,
    input  logic [2:0][W-1:0] raddr,
    output logic [2:0][W-1:0] rdata
);

    logic [W-1:0] mem [2**W];

    // Table contents carry no reset; the controller rewrites them in INIT.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_rd
        assign rdata[c] = mem[raddr[c]];
    end

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered gamma correction: active bank drives the pixel path, the
// shadow bank is host-written and swapped in only at a frame boundary.
module gamma_lut_ctrl
    import gamma_lut_ctrl_pkg::*;
#(
    parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
    parameter int FS_BIT      = FS_BIT_POS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_ready,
    input  logic                        i_valid,
    input  logic [2:0][COLOR_DEPTH-1:0] i_data,
    output logic                        o_ready,
    output logic                        o_valid,
    output logic [2:0][COLOR_DEPTH-1:0] o_data,
    input  logic [7:0]                  i_user,
    output logic [7:0]                  o_user,
    input  logic [15:0]                 isp_ctrl,
    input  logic                        cfg_we,
    input  logic [COLOR_DEPTH-1:0]      cfg_addr,
    input  logic [COLOR_DEPTH-1:0]      cfg_wdata,
    input  logic                        cfg_commit,
    output logic                        cfg_busy,
    output logic                        cfg_pending,
    output logic                        active_bank
);

    gamma_lut_state_t state, state_nxt;

    logic [COLOR_DEPTH-1:0]      cnt;
    logic                        gamma_en;
    logic                        fs_beat;
    logic                        swap;
    logic                        sel_p0;
    logic                        bypass_p0;
    logic                        we0, we1;
    logic [COLOR_DEPTH-1:0]      waddr, wdata;
    logic [2:0][COLOR_DEPTH-1:0] rd0, rd1, lut_p0;
    logic                        vld_p1;
    logic [2:0][COLOR_DEPTH-1:0] data_p1;
    logic [7:0]                  user_p1;
    logic                        unused_isp;

    assign unused_isp = ^isp_ctrl[14:1];

    assign gamma_en = isp_ctrl[0] & isp_ctrl[15];
    assign fs_beat  = i_valid & i_user[FS_BIT];
    assign swap     = (state == PEND) && (fs_beat || !gamma_en);

    // The frame-start beat that triggers the swap already reads the new bank.
    assign sel_p0    = ((state == PEND) && fs_beat) ? ~active_bank : active_bank;
    assign bypass_p0 = !gamma_en || (state == INIT);

    // INIT fills both banks with identity; afterwards only the shadow is writable.
    assign waddr = (state == INIT) ? cnt : cfg_addr;
    assign wdata = (state == INIT) ? cnt : cfg_wdata;
    assign we0   = (state == INIT) || ((state == IDLE) && cfg_we && active_bank);
    assign we1   = (state == INIT) || ((state == IDLE) && cfg_we && !active_bank);

    gamma_lut_bank #(.W(COLOR_DEPTH)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (i_data),
        .rdata (rd0)
    );

    gamma_lut_bank #(.W(COLOR_DEPTH)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (i_data),
        .rdata (rd1)
    );

    for (genvar c = 0; c < 3; c++) begin : g_sel
        assign lut_p0[c] = sel_p0 ? rd1[c] : rd0[c];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: if (cnt == {COLOR_DEPTH{1'b1}}) state_nxt = IDLE;
            IDLE: if (cfg_commit) state_nxt = PEND;
            PEND: if (swap) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            cnt         <= '0;
            active_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
            if (swap) begin
                active_bank <= ~active_bank;
            end
        end
    end

    // p0 -> p1: lookup result registered; data/user hold while no beat arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            user_p1 <= '0;
        end else begin
            vld_p1 <= i_valid;
            if (i_valid) begin
                data_p1 <= bypass_p0 ? i_data : lut_p0;
                user_p1 <= i_user;
            end
        end
    end

    assign o_ready     = i_ready;
    assign o_valid     = vld_p1;
    assign o_data      = data_p1;
    assign o_user      = user_p1;
    assign cfg_busy    = (state != IDLE);
    assign cfg_pending = (state == PEND);

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Directed bench for gamma_lut_ctrl: init timing, shadow commit/swap on frame
// start and on gamma disable, reset during a pending commit, valid/user pass-through.
module tb_gamma_lut_ctrl;
    import gamma_lut_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_ready;
    logic            i_valid;
    logic [2:0][7:0] i_data;
    logic            o_ready;
    logic            o_valid;
    logic [2:0][7:0] o_data;
    logic [7:0]      i_user;
    logic [7:0]      o_user;
    logic [15:0]     isp_ctrl;
    logic            cfg_we;
    logic [7:0]      cfg_addr;
    logic [7:0]      cfg_wdata;
    logic            cfg_commit;
    logic            cfg_busy;
    logic            cfg_pending;
    logic            active_bank;

    int nvec = 0;
    int nerr = 0;

    gamma_lut_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_ready     (i_ready),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_user      (i_user),
        .o_user      (o_user),
        .isp_ctrl    (isp_ctrl),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_busy    (cfg_busy),
        .cfg_pending (cfg_pending),
        .active_bank (active_bank)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] user);
        i_valid = 1'b1;
        i_data  = {r, g, b};
        i_user  = user;
    endtask

    initial begin
        int n;
        logic       v;
        logic [7:0] u, last_u;
        logic       rdy;

        rst = 1'b1; i_ready = 1'b1; i_valid = 1'b0; i_data = '0; i_user = '0;
        isp_ctrl = 16'h8001; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        tick();
        tick();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_user", o_user, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_bank", active_bank, 0);
        chk("rst_busy", cfg_busy, 1);

        // Test 1: INIT length and identity table
        rst = 1'b0;
        n = 0;
        while (cfg_busy && n < 1000) begin
            n++;
            tick();
        end
        chk("init_cycles", n, GAMMA_LUT_DEPTH);
        pix(8'd10, 8'd128, 8'd255, 8'h00);
        tick();
        chk("ident_data", o_data, {8'd10, 8'd128, 8'd255});
        chk("ident_valid", o_valid, 1);
        i_valid = 1'b0;
        tick();
        chk("gap_valid", o_valid, 0);
        chk("gap_hold", o_data, {8'd10, 8'd128, 8'd255});

        // Test 2: inverted table into shadow bank 1, commit, frame-start swap
        for (int x = 0; x < GAMMA_LUT_DEPTH; x++) begin
            cfg_we = 1'b1; cfg_addr = 8'(x); cfg_wdata = 8'(255 - x);
            tick();
        end
        cfg_we = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("commit_pending", cfg_pending, 1);
        chk("commit_busy", cfg_busy, 1);
        pix(8'd5, 8'd5, 8'd5, 8'h00);
        tick();
        chk("pend_data", o_data, 24'h050505);
        // Test 3: write while pending must be ignored
        cfg_we = 1'b1; cfg_addr = 8'd5; cfg_wdata = 8'd0;
        tick();
        cfg_we = 1'b0;
        chk("pend_data2", o_data, 24'h050505);
        chk("pend_still", cfg_pending, 1);
        pix(8'd5, 8'd5, 8'd5, 8'h01);
        tick();
        chk("fs_swap_data", o_data, 24'hfafafa);
        chk("fs_swap_user", o_user, 8'h01);
        chk("fs_swap_bank", active_bank, 1);
        chk("fs_swap_pend", cfg_pending, 0);
        pix(8'd5, 8'd5, 8'd5, 8'h00);
        tick();
        chk("pend_write_ignored", o_data, 24'hfafafa);

        // Test 4: bank0[9]=0x11 via shadow, then swap caused by gamma_en=0
        i_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 8'd9; cfg_wdata = 8'h11;
        tick();
        cfg_we = 1'b0;
        isp_ctrl = 16'h0001;
        cfg_commit = 1'b1;
        pix(8'd5, 8'd5, 8'd5, 8'h00);
        tick();
        cfg_commit = 1'b0;
        chk("dis_bypass1", o_data, 24'h050505);
        chk("dis_pending", cfg_pending, 1);
        tick();
        chk("dis_bypass2", o_data, 24'h050505);
        chk("dis_bank", active_bank, 0);
        chk("dis_pend_clr", cfg_pending, 0);
        isp_ctrl = 16'h8001;
        pix(8'd9, 8'd9, 8'd9, 8'h00);
        tick();
        chk("bank0_written", o_data, 24'h111111);

        // Simultaneous write and commit: the commit includes the write
        i_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 8'd7; cfg_wdata = 8'h33; cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        chk("wc_pending", cfg_pending, 1);
        pix(8'd7, 8'd7, 8'd7, 8'h01);
        tick();
        chk("wc_data", o_data, 24'h333333);
        chk("wc_bank", active_bank, 1);

        // Test 5: reset while a commit is pending and pixels stream
        i_valid = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        pix(8'd7, 8'd7, 8'd7, 8'h00);
        tick();
        chk("pre_rst_data", o_data, 24'h333333);
        chk("pre_rst_pend", cfg_pending, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_pend", cfg_pending, 0);
        chk("mid_rst_bank", active_bank, 0);
        rst = 1'b0;
        pix(8'd9, 8'd9, 8'd9, 8'h00);
        tick();
        n = 1;
        chk("init_bypass", o_data, 24'h090909);
        i_valid = 1'b0;
        while (cfg_busy && n < 1000) begin
            n++;
            tick();
        end
        chk("reinit_cycles", n, GAMMA_LUT_DEPTH);
        pix(8'd5, 8'd9, 8'd7, 8'h00);
        tick();
        chk("reinit_ident", o_data, {8'd5, 8'd9, 8'd7});

        // Test 6: random valid gaps, user patterns and ready
        last_u = o_user;
        for (int k = 0; k < 24; k++) begin
            v   = 1'($urandom_range(0, 1));
            u   = 8'($urandom);
            rdy = 1'($urandom_range(0, 1));
            i_valid = v; i_user = u; i_ready = rdy;
            i_data = {8'(k), 8'(k + 1), 8'(k + 2)};
            #1;
            chk("o_ready", o_ready, rdy);
            tick();
            if (v) last_u = u;
            chk("rnd_valid", o_valid, v);
            chk("rnd_user", o_user, last_u);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
